// File: rtl/reg_wb_writer_if.sv
// Bundle of ALU/load result handshakes, reg_file write port and forwarding lookups
// seen by the register-file write-back initiator.
interface reg_wb_writer_if #(parameter int AW = 2);
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_wn;
  logic [31:0] alu_wd;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_wn;
  logic [31:0] ld_wd;
  logic        RegWrite;
  logic [4:0]  WN;
  logic [31:0] WD;
  logic [4:0]  RN1, RN2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic [AW:0] fifo_cnt;

  modport master (
    input  alu_valid, alu_wn, alu_wd, ld_valid, ld_wn, ld_wd, RN1, RN2,
    output alu_ready, ld_ready, RegWrite, WN, WD,
           fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, fifo_cnt
  );

  modport slave (
    output alu_valid, alu_wn, alu_wd, ld_valid, ld_wn, ld_wd, RN1, RN2,
    input  alu_ready, ld_ready, RegWrite, WN, WD,
           fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, fifo_cnt
  );
endinterface

// File: rtl/reg_wb_writer.sv
// Register-file write-back initiator: arbitrates ALU results and an in-order load FIFO onto
// the single reg_file write port, with WAW kill and per-read-port forwarding lookup.
module reg_wb_fwd #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic [4:0]                  rn,
  input  logic [DEPTH-1:0]            vld,
  input  logic [DEPTH-1:0][4:0]       ewn,
  input  logic [DEPTH-1:0][31:0]      ewd,
  input  logic [AW-1:0]               rd_ptr,
  input  logic                        regwrite,
  input  logic [4:0]                  wn,
  input  logic [31:0]                 wd,
  output logic                        hit,
  output logic [31:0]                 data
);
  logic [AW-1:0] idx;

  // Output register is oldest; walk FIFO oldest->youngest so the youngest match wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    if (rn != 5'd0) begin
      if (regwrite && wn == rn) begin
        hit  = 1'b1;
        data = wd;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + AW'(k);
        if (vld[idx] && ewn[idx] == rn) begin
          hit  = 1'b1;
          data = ewd[idx];
        end
      end
    end
  end
endmodule

module reg_wb_writer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  reg_wb_writer_if.master   bus
);
  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [DEPTH-1:0][4:0]  ewn_q, ewn_d;
  logic [DEPTH-1:0][31:0] ewd_q, ewd_d;
  logic [AW-1:0]          rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic                   regwrite_q, regwrite_d;
  logic [4:0]             wn_q, wn_d;
  logic [31:0]            wd_q, wd_d;

  logic full, empty, alu_fire, ld_fire, pop, push;

  always_comb begin
    full     = (cnt_q == (AW+1)'(DEPTH));
    empty    = (cnt_q == '0);
    alu_fire = bus.alu_valid && !full;
    ld_fire  = bus.ld_valid && !full;
    pop      = !empty && !alu_fire;
    // Same-register load alongside an ALU write is older, so it is swallowed.
    push     = ld_fire && (bus.ld_wn != 5'd0) &&
               !(alu_fire && bus.alu_wn == bus.ld_wn);

    vld_d      = vld_q;
    ewn_d      = ewn_q;
    ewd_d      = ewd_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    regwrite_d = 1'b0;
    wn_d       = wn_q;
    wd_d       = wd_q;

    if (alu_fire) begin
      if (bus.alu_wn != 5'd0) begin
        regwrite_d = 1'b1;
        wn_d       = bus.alu_wn;
        wd_d       = bus.alu_wd;
        for (int i = 0; i < DEPTH; i++)
          if (vld_q[i] && ewn_q[i] == bus.alu_wn) vld_d[i] = 1'b0;
      end
    end else if (pop) begin
      // Killed heads still consume the port slot, just without a strobe.
      if (vld_q[rd_q]) begin
        regwrite_d = 1'b1;
        wn_d       = ewn_q[rd_q];
        wd_d       = ewd_q[rd_q];
      end
      vld_d[rd_q] = 1'b0;
      rd_d        = rd_q + AW'(1);
    end

    if (push) begin
      vld_d[wr_q] = 1'b1;
      ewn_d[wr_q] = bus.ld_wn;
      ewd_d[wr_q] = bus.ld_wd;
      wr_d        = wr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      ewn_q      <= '0;
      ewd_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      regwrite_q <= 1'b0;
      wn_q       <= '0;
      wd_q       <= '0;
    end else begin
      vld_q      <= vld_d;
      ewn_q      <= ewn_d;
      ewd_q      <= ewd_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      regwrite_q <= regwrite_d;
      wn_q       <= wn_d;
      wd_q       <= wd_d;
    end
  end

  assign bus.alu_ready = !full;
  assign bus.ld_ready  = !full;
  assign bus.RegWrite  = regwrite_q;
  assign bus.WN        = wn_q;
  assign bus.WD        = wd_q;
  assign bus.fifo_cnt  = cnt_q;

  logic [1:0][4:0]  rn;
  logic [1:0]       hit;
  logic [1:0][31:0] fdata;

  assign rn = {bus.RN2, bus.RN1};

  for (genvar p = 0; p < 2; p++) begin : g_fwd
    reg_wb_fwd #(.DEPTH(DEPTH), .AW(AW)) u_fwd (
      .rn(rn[p]), .vld(vld_q), .ewn(ewn_q), .ewd(ewd_q), .rd_ptr(rd_q),
      .regwrite(regwrite_q), .wn(wn_q), .wd(wd_q),
      .hit(hit[p]), .data(fdata[p])
    );
  end

  assign bus.fwd1_hit  = hit[0];
  assign bus.fwd2_hit  = hit[1];
  assign bus.fwd1_data = fdata[0];
  assign bus.fwd2_data = fdata[1];
endmodule
